// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the parity helper.
// Used by uart_rx and uart_tx.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_t;

  // True when data plus the received parity bit hold an even number of ones.
  function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data,
                                          input logic                 parity);
    return ~((^data) ^ parity);
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// Both flops reset to RST_VAL so the output is quiet straight after reset.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: recovers LSB-first 8N1 frames and emits one byte per frame.
// Optional even-parity support when UART_RX_PARITY_EN is defined (adds parity_error).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 rx_busy,
  output logic                 frame_error
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit;
`endif

  uart_sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  assign rx_busy = (state != IDLE);

  // Every sample point sits mid-bit: half a bit after the start edge, then whole bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift_reg     <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      frame_error   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit    <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      rx_data_valid <= 1'b0;
      frame_error   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift_reg[idx] <= rx_s;
            idx            <= idx + 3'd1;
            if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            parity_bit <= rx_s;
            state      <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        // Leaving at mid-stop-bit lets a start bit follow with no idle time.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (!even_parity_ok(shift_reg, parity_bit)) begin
                parity_error <= 1'b1;
              end else begin
                rx_data       <= shift_reg;
                rx_data_valid <= 1'b1;
              end
`else
              rx_data       <= shift_reg;
              rx_data_valid <= 1'b1;
`endif
              state <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit, directed scenarios plus random frames.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  localparam int K_VALID = 0;
  localparam int K_FE    = 1;
  localparam int K_PE    = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_busy;
  logic       frame_error;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  int  cyc      = 0;
  int  checks   = 0;
  int  errors   = 0;
  int  both_cnt = 0;
  ev_t exp_q[$];
  ev_t got_q[$];
  logic [7:0] b;
  logic [7:0] last_byte;
  int  c0;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_busy      (rx_busy),
    .frame_error  (frame_error)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error (parity_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse with the index of the edge that produced it.
  always @(negedge clk) begin
    if (reset) begin
      if (rx_data_valid) got_q.push_back('{cyc, K_VALID, rx_data});
      if (frame_error)   got_q.push_back('{cyc, K_FE, 8'h00});
`ifdef UART_RX_PARITY_EN
      if (parity_error)  got_q.push_back('{cyc, K_PE, 8'h00});
`endif
      if (rx_data_valid && frame_error) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; leaves rx at the stop-bit level after the stop bit.
  task automatic apply_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    int   start;
    int   kind;
    start = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_EN != 0) begin
      rx = par_bit;
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    if (!stop_bit)                            kind = K_FE;
    else if (PAR_EN != 0 && ((^d) != par_bit)) kind = K_PE;
    else                                      kind = K_VALID;
    // Pulse appears 3 clocks after the middle of the stop bit.
    exp_q.push_back('{start + (9 + PAR_EN) * CPB + CPB / 2 + 3, kind, d});
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic check_output(input string tag);
    ev_t e;
    ev_t g;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_cycle"}, g.cyc, e.cyc);
      chk({tag, "_kind"}, g.kind, e.kind);
      if (e.kind == K_VALID) chk({tag, "_data"}, {24'h0, g.data}, {24'h0, e.data});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", {24'h0, rx_data}, 32'h0);
    chk("reset_valid", {31'h0, rx_data_valid}, 32'h0);
    chk("reset_busy", {31'h0, rx_busy}, 32'h0);
    chk("reset_frame_error", {31'h0, frame_error}, 32'h0);
    reset = 1'b1;
    idle_bits(2);

    $display("[TB] single frame 0x55");
    apply_frame(8'h55, 1'b1, 1'b0);
    idle_bits(2);
    check_output("frame55");

    $display("[TB] back-to-back 0xA3, 0x0F");
    apply_frame(8'hA3, 1'b1, 1'b0);
    apply_frame(8'h0F, 1'b1, 1'b0);
    idle_bits(2);
    check_output("b2b");
    chk("b2b_hold", {24'h0, rx_data}, 32'h0F);

    $display("[TB] 6-clock glitch");
    c0 = cyc;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_high", {31'h0, rx_busy}, 32'h1);
    repeat (6) @(negedge clk);
    chk("glitch_elapsed", cyc - c0, 32'd12);
    chk("glitch_busy_low", {31'h0, rx_busy}, 32'h0);
    idle_bits(2);
    check_output("glitch");

    $display("[TB] bad stop bit then line held low");
    apply_frame(8'h3C, 1'b0, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    chk("break_busy", {31'h0, rx_busy}, 32'h1);
    check_output("break");
    idle_bits(1);
    chk("break_release_busy", {31'h0, rx_busy}, 32'h0);
    apply_frame(8'h81, 1'b1, 1'b0);
    idle_bits(2);
    check_output("after_break");
    chk("after_break_data", {24'h0, rx_data}, 32'h81);

    $display("[TB] reset mid-frame");
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midreset_busy", {31'h0, rx_busy}, 32'h0);
    chk("midreset_data", {24'h0, rx_data}, 32'h0);
    repeat (8 * CPB) @(negedge clk);
    check_output("midreset");
    apply_frame(8'h7E, 1'b1, 1'b0);
    idle_bits(2);
    check_output("after_reset");

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity frames");
    apply_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    apply_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    check_output("parity");
`endif

    $display("[TB] random frames");
    last_byte = rx_data;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      apply_frame(b, 1'b1, ^b);
      last_byte = b;
      idle_bits($urandom_range(0, 2));
    end
    idle_bits(2);
    check_output("random");
    chk("random_hold", {24'h0, rx_data}, {24'h0, last_byte});
    chk("valid_fe_exclusive", both_cnt, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART path: oversamples the asynchronous rx line, recovers 8N1 frames (LSB first) and emits one byte per frame.
- Output is a one-cycle valid pulse that feeds uart_mmio directly: rx_data goes to its rx_data, rx_data_valid goes to its rx_data_valid.
- Has no backpressure. uart_mmio is always ready to receive.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit period (100 MHz / 115200). Must be >= 4. Simulation uses 16.
- CNT_W, 16: width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset; the block is held in reset while low.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  received byte; only meaningful while rx_data_valid=1.
- rx_data_valid  output  1  one-cycle pulse per good frame.
- rx_busy  output  1  high in any state other than IDLE.
- frame_error  output  1  one-cycle pulse when the stop bit samples low.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; all counters cleared.
  - Outputs: rx_data=8'h00, rx_data_valid=0, rx_busy=0, frame_error=0.
  - Both synchronizer flops are preset to 1, so no false start is seen after reset.
  - Reset asserted mid-frame abandons the frame; no pulse is emitted.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s==0 → START; counter cleared.
- START:
  - Counts to (CLKS_PER_BIT/2)-1, using integer division.
  - rx_s==1 at that point is a false start → IDLE, no output.
  - Otherwise → DATA with counter=0 and bit index=0.
- DATA:
  - Samples rx_s when the counter reaches CLKS_PER_BIT-1 (mid-bit), then resets the counter.
  - The sample shifts into bit[idx], LSB first.
  - After idx==7 is sampled → STOP. idx is 3 bits and wraps naturally.
- STOP:
  - Samples at CLKS_PER_BIT-1.
  - rx_s==1: rx_data <= shift reg; rx_data_valid=1 on the following cycle; → IDLE.
  - rx_s==0: frame_error=1 on the following cycle; rx_data is unchanged and no valid pulse is issued; → WAIT_IDLE.
- WAIT_IDLE:
  - Stays until rx_s==1 (break/line-low handling), then → IDLE.
  - Prevents a held-low line from producing repeated frames.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with zero idle bits.
- Latency: rx_data_valid rises 2 (sync) + 1 clk after the mid-stop-bit sample edge on rx.
- rx_data holds its value until the next good frame.
- rx_data_valid and frame_error are never high in the same cycle.
- Counter arithmetic is unsigned CNT_W bits. The counter never exceeds CLKS_PER_BIT-1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - An EVEN parity bit follows bit 7; a PARITY state is inserted between DATA and STOP, sampled at mid-bit.
  - New output port parity_error (1 bit) is added. It pulses one cycle, in place of rx_data_valid, when the parity mismatches and the stop bit is good.
  - Stop failure takes priority: frame_error only.
  - rx_data is not updated on a parity error.
- When undefined: 8N1 only, no PARITY state, no parity_error port.

Decomposition:
- Shared package uart_pkg:
  - FSM state typedef with encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_IDLE=5.
  - Constants DATA_BITS=8 and DEFAULT_CLKS_PER_BIT=868, also used by uart_tx.
- One sub-module: uart_sync_2ff, a 2-flop synchronizer with reset value parameter RST_VAL=1. It is reused by other async inputs.

Test Plan (CLKS_PER_BIT=16):
- Send 8'h55 as an 8N1 frame: exactly one rx_data_valid pulse with rx_data=8'h55, 3 clk after the stop-bit midpoint; frame_error stays 0.
- Send 8'hA3 then immediately 8'h0F with no idle bit between them: two valid pulses 160 clk apart, carrying data A3 then 0F.
- Drive a 6-clk low glitch on idle rx: the glitch is rejected as a false start; no pulses; rx_busy returns to 0 within 12 clk.
- Send 8'h3C with the stop bit driven low, then hold rx low for 40 bit-times: one frame_error pulse, no valid, state held in WAIT_IDLE. Then send 8'h81: valid with data 81.
- Assert reset=0 for 1 clk midway through the data bits of 8'hFF, then release: no pulse, rx_busy=0, rx_data=00. The next frame 8'h7E is received correctly.
- (UART_RX_PARITY_EN) Send 8'h07 with parity=0, which is wrong since even parity requires 1: parity_error pulses, no valid. The same byte with parity=1: valid with data 07.
